// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that takes a framed byte stream over valid/ready,
// assembles little-endian 32-bit words into imem from address 0, checks an XOR
// checksum over the payload, and then releases the cpu via cpu_run.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              error,
  output logic              busy,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CNT_W = ADDR_W + 1;
  // Largest legal word count, widened to 17 bits so the full 16-bit N compares cleanly.
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    PAYLOAD,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t           state;
  logic [7:0]       n_lo;
  logic [CNT_W-1:0] n_words;
  logic [1:0]       byte_idx;
  logic [CNT_W-1:0] word_idx;
  logic [31:0]      asm_word;
  logic [7:0]       csum;

  logic             accept;
  logic [16:0]      n_full;
  logic [CNT_W-1:0] word_idx_nxt;

  // Byte acceptance is decoded straight from the state so a byte can land every cycle.
  always_comb begin
    rx_ready     = (state == HDR0) || (state == HDR1) || (state == PAYLOAD) || (state == CHECK);
    accept       = rx_valid && rx_ready;
    n_full       = {1'b0, rx_data, n_lo};
    word_idx_nxt = word_idx + CNT_W'(1);
  end

  // Frame FSM with all outputs registered; the last write and cpu_run can never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HDR0;
      n_lo         <= '0;
      n_words      <= '0;
      byte_idx     <= '0;
      word_idx     <= '0;
      asm_word     <= '0;
      csum         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_run      <= 1'b0;
      error        <= 1'b0;
      busy         <= 1'b1;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          HDR0: begin
            n_lo  <= rx_data;
            state <= HDR1;
          end
          HDR1: begin
            if (n_full > CAPACITY) begin
              state <= ERROR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else if (n_full == 17'd0) begin
              state <= CHECK;
            end else begin
              n_words <= n_full[CNT_W-1:0];
              state   <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            asm_word[{byte_idx, 3'b000} +: 8] <= rx_data;
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we      <= 1'b1;
              imem_addr    <= word_idx[ADDR_W-1:0];
              imem_wdata   <= {rx_data, asm_word[23:0]};
              word_idx     <= word_idx_nxt;
              words_loaded <= word_idx_nxt;
              if (word_idx_nxt == n_words) begin
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            busy <= 1'b0;
            if (rx_data == csum) begin
              state   <= DONE;
              cpu_run <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: single word, gapped two-word frame, bad checksum,
// oversize/full/empty headers and reset in the middle of a frame.
module tb_imem_loader;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [7:0]        rx_data = 8'h00;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              error;
  logic              busy;
  logic [ADDR_W:0]   words_loaded;

  int errors = 0;
  int checks = 0;

  logic [7:0]        fr [0:299];
  int                wr_cnt = 0;
  logic [ADDR_W-1:0] wr_addr [0:255];
  logic [31:0]       wr_data [0:255];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .error(error), .busy(busy), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write log, sampled mid-cycle while the registered strobe is stable.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (wr_cnt < 256) begin
        wr_addr[wr_cnt] <= imem_addr;
        wr_data[wr_cnt] <= imem_wdata;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Sends fr[0:len-1]; after every 4th payload byte checks the one-cycle write pulse.
  task automatic send_frame(input int len, input bit gaps);
    int k;
    for (int i = 0; i < len; i++) begin
      send_byte(fr[i]);
      if (i >= 2 && i < len - 1 && ((i - 2) % 4) == 3) begin
        k = (i - 2) / 4;
        check("we_pulse", {31'd0, imem_we}, 32'd1);
        check("we_addr", {26'd0, imem_addr}, k);
        check("we_data", imem_wdata, {fr[i], fr[i-1], fr[i-2], fr[i-3]});
        check("words_loaded", {25'd0, words_loaded}, k + 1);
        idle(1);
        check("we_single", {31'd0, imem_we}, 32'd0);
      end else if (gaps) begin
        idle($urandom_range(0, 2));
      end
    end
  endtask

  task automatic load_two_word();
    fr[0] = 8'h02; fr[1] = 8'h00;
    fr[2] = 8'h05; fr[3] = 8'h00; fr[4] = 8'h08; fr[5] = 8'h20;
    fr[6] = 8'h00; fr[7] = 8'h00; fr[8] = 8'h08; fr[9] = 8'hAC;
    fr[10] = 8'h89;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
    check({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    check({tag, "_addr"}, {26'd0, imem_addr}, 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_cpu_run"}, {31'd0, cpu_run}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_words"}, {25'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    int base;
    logic [7:0] x;

    // Reset state
    do_reset();
    check_reset_state("rst");

    // Single word, back-to-back
    fr[0] = 8'h01; fr[1] = 8'h00; fr[2] = 8'h78; fr[3] = 8'h56;
    fr[4] = 8'h34; fr[5] = 8'h12; fr[6] = 8'h08;
    base = wr_cnt;
    send_frame(7, 1'b0);
    check("s_cpu_run", {31'd0, cpu_run}, 32'd1);
    check("s_error", {31'd0, error}, 32'd0);
    check("s_busy", {31'd0, busy}, 32'd0);
    check("s_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("s_words", {25'd0, words_loaded}, 32'd1);
    check("s_nwrites", wr_cnt - base, 32'd1);
    check("s_addr0", {26'd0, wr_addr[base]}, 32'd0);
    check("s_data0", wr_data[base], 32'h12345678);

    // Two words with random gaps
    do_reset();
    load_two_word();
    base = wr_cnt;
    send_frame(11, 1'b1);
    check("t_cpu_run", {31'd0, cpu_run}, 32'd1);
    check("t_error", {31'd0, error}, 32'd0);
    check("t_nwrites", wr_cnt - base, 32'd2);
    check("t_addr0", {26'd0, wr_addr[base]}, 32'd0);
    check("t_data0", wr_data[base], 32'h20080005);
    check("t_addr1", {26'd0, wr_addr[base+1]}, 32'd1);
    check("t_data1", wr_data[base+1], 32'hAC080000);
    check("t_words", {25'd0, words_loaded}, 32'd2);

    // Bad checksum
    do_reset();
    fr[0] = 8'h01; fr[1] = 8'h00; fr[2] = 8'h78; fr[3] = 8'h56;
    fr[4] = 8'h34; fr[5] = 8'h12; fr[6] = 8'h09;
    base = wr_cnt;
    send_frame(7, 1'b0);
    check("b_error", {31'd0, error}, 32'd1);
    check("b_cpu_run", {31'd0, cpu_run}, 32'd0);
    check("b_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("b_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    idle(2);
    check("b_nwrites", wr_cnt - base, 32'd1);
    check("b_data0", wr_data[base], 32'h12345678);
    check("b_words", {25'd0, words_loaded}, 32'd1);
    check("b_error_hold", {31'd0, error}, 32'd1);

    // Oversize header 0x0041
    do_reset();
    base = wr_cnt;
    send_byte(8'h41);
    check("o_busy_mid", {31'd0, busy}, 32'd1);
    send_byte(8'h00);
    check("o_error", {31'd0, error}, 32'd1);
    check("o_busy", {31'd0, busy}, 32'd0);
    check("o_rx_ready", {31'd0, rx_ready}, 32'd0);
    idle(2);
    check("o_nwrites", wr_cnt - base, 32'd0);

    // Oversize by the high byte only (0x0100 > 64)
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    check("oh_error", {31'd0, error}, 32'd1);

    // Full memory: 64 words
    do_reset();
    fr[0] = 8'h40; fr[1] = 8'h00;
    x = 8'h00;
    for (int j = 0; j < 256; j++) begin
      fr[2+j] = 8'((j * 7 + 3) & 255);
      x = x ^ fr[2+j];
    end
    fr[258] = x;
    base = wr_cnt;
    send_frame(259, 1'b0);
    check("f_cpu_run", {31'd0, cpu_run}, 32'd1);
    check("f_error", {31'd0, error}, 32'd0);
    check("f_words", {25'd0, words_loaded}, 32'd64);
    check("f_nwrites", wr_cnt - base, 32'd64);
    for (int k = 0; k < 64; k++) begin
      check("f_addr", {26'd0, wr_addr[base+k]}, k);
      check("f_data", wr_data[base+k], {fr[2+4*k+3], fr[2+4*k+2], fr[2+4*k+1], fr[2+4*k]});
    end

    // Empty frame
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    check("e_busy_mid", {31'd0, busy}, 32'd1);
    check("e_run_mid", {31'd0, cpu_run}, 32'd0);
    send_byte(8'h00);
    check("e_cpu_run", {31'd0, cpu_run}, 32'd1);
    check("e_error", {31'd0, error}, 32'd0);
    check("e_words", {25'd0, words_loaded}, 32'd0);

    // Reset after byte 3 of word 1, then full resend
    do_reset();
    load_two_word();
    send_frame(9, 1'b0);
    check("r_words_pre", {25'd0, words_loaded}, 32'd1);
    do_reset();
    check_reset_state("rmid");
    load_two_word();
    base = wr_cnt;
    send_frame(11, 1'b0);
    check("r_cpu_run", {31'd0, cpu_run}, 32'd1);
    check("r_nwrites", wr_cnt - base, 32'd2);
    check("r_data0", wr_data[base], 32'h20080005);
    check("r_data1", wr_data[base+1], 32'hAC080000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader sitting directly upstream of the cpu's instruction memory on the mother board. It receives a framed byte stream over a valid/ready link and assembles little-endian 32-bit words. It writes those words into consecutive imem addresses from 0, verifies an XOR checksum, and only then asserts `cpu_run` to release the cpu. On any framing or checksum failure it parks in an error state with the cpu held.

## Interface
- `ADDR_W`, default 6: imem word-address width; capacity is 2**ADDR_W words.
- `clk  in  1`: single system clock; all state updates on its rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `rx_valid  in  1`: byte on `rx_data` is valid.
- `rx_ready  out  1`: loader accepts a byte this cycle; a transfer occurs on an edge where `rx_valid && rx_ready`.
- `rx_data  in  8`: stream byte.
- `imem_we  out  1`: imem write strobe, one cycle per word.
- `imem_addr  out  ADDR_W`: word address of the write.
- `imem_wdata  out  32`: word to write.
- `cpu_run  out  1`: level; 1 releases the cpu. It is driven as the cpu's reset-deassert.
- `error  out  1`: level; load failed.
- `busy  out  1`: 1 while in HDR0..CHECK.
- `words_loaded  out  ADDR_W+1`: count of words written so far.

## Operation
- Frame format: N_lo, N_hi (16-bit word count N, LE), then 4N payload bytes (each word LE, byte 0 first), then one checksum byte. The checksum is the XOR of all 4N payload bytes; header bytes are excluded.
- States: HDR0, HDR1, PAYLOAD, CHECK, DONE, ERROR. After reset the state is HDR0.
- HDR0 accepts N_lo and moves to HDR1.
- HDR1 accepts N_hi and moves on as follows:
  - N > 2**ADDR_W: ERROR.
  - N == 0: CHECK.
  - Otherwise: PAYLOAD.
- PAYLOAD tracks the byte-in-word index (2 bits) and the word index.
  - Each accepted byte is shifted into the assembly register at position `8*idx` and XORed into the running checksum.
  - On the 4th byte, the write is registered, the word index increments, and `words_loaded` increments.
  - When word index reaches N, the state moves to CHECK.
- CHECK accepts one byte. If it equals the running XOR, the state moves to DONE; otherwise it moves to ERROR.
- DONE is terminal: `cpu_run`=1, `rx_ready`=0.
- ERROR is terminal: `error`=1, `cpu_run`=0, `rx_ready`=0. Leaving DONE or ERROR requires `rst`.
- `rx_ready`=1 in HDR0, HDR1, PAYLOAD and CHECK. No back-pressure is needed for the imem write.
- Bytes presented in DONE or ERROR are not accepted. `rx_valid`=0 cycles stall the FSM with no side effects.
- Arithmetic rules:
  - Word index and `words_loaded` are ADDR_W+1 bits wide; `imem_addr` is the low ADDR_W bits.
  - N == 2**ADDR_W is legal and fills memory exactly; the address never wraps.
  - The N compare uses the full 16 bits.
- Reset mid-operation returns to HDR0 and clears the index, checksum, `words_loaded` and all outputs. Already-written imem contents are not touched.

## Timing
- Reset values: `rx_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_run`=0, `error`=0, `busy`=1, `words_loaded`=0.
- All outputs are registered, except `rx_ready`, which is decoded from the state register.
- Word write latency: when the 4th byte of word k is accepted at edge t, the following hold during cycle t..t+1:
  - `imem_we`=1 for exactly one cycle.
  - `imem_addr`=k.
  - `imem_wdata`=assembled word.
  - `words_loaded`=k+1.
- The next byte may be accepted at edge t+1, simultaneously with the write; that is the minimum spacing.
- Checksum byte accepted at edge t: from cycle t+1, `busy`=0 and either `cpu_run` or `error` is 1. The last imem write always completes at or before that edge, so the cpu never runs ahead of its image.
- Minimum frame time for back-to-back bytes: 2+4N+1 cycles from first byte to `cpu_run`.

## Test plan
- Single word: bytes 01 00 78 56 34 12 08, valid every cycle.
  - One `imem_we` pulse with addr 0, data 0x12345678.
  - `words_loaded`=1.
  - `cpu_run`=1 the cycle after 08 is accepted; `error`=0.
- Two words with gaps: bytes 02 00 05 00 08 20 00 00 08 AC 89, random `rx_valid` gaps.
  - Writes addr0=0x20080005, addr1=0xAC080000.
  - Each write lands exactly one cycle after its 4th byte.
  - Then `cpu_run`=1.
- Bad checksum: same as the single-word scenario with final byte 09.
  - Write to addr 0 still occurs.
  - `error`=1, `cpu_run`=0, `rx_ready`=0; further bytes are ignored.
- Oversize and empty (ADDR_W=6):
  - Header 41 00 gives `error`=1 right after N_hi, with no writes.
  - Header 40 00 with 256 bytes and the correct XOR gives 64 writes, addr 0..63, no wrap, and `cpu_run`=1.
  - Header 00 00 followed by 00 gives `cpu_run`=1.
- Reset mid-frame: assert `rst` after byte 3 of word 1 of the two-word frame.
  - All outputs return to reset values.
  - A full resend of the two-word frame then loads correctly and asserts `cpu_run`.
